conv_tap_sequencer: RTL and testbench

// Scheduler for the convolution multiply-accumulate datapath. On start, it walks every
// (channel, image row, image column, kernel row, kernel column) tap of a 3-channel image.
// For each tap it issues one valid/ready transaction carrying the source coordinates, the
// pad flag and the accumulator framing flags.

---
 rtl/conv_tap_sequencer_if.sv | 27 ++
 rtl/conv_tap_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_conv_tap_sequencer.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/conv_tap_sequencer_if.sv
// Tap bus from the convolution sequencer to the multiply/accumulate datapath.
// Plain valid/ready handshake: the payload is held stable while valid is high and ready is low.
interface conv_tap_sequencer_if #(
  parameter int COORD_W = 16,
  parameter int KSIZE_W = 4
);
  logic               tap_valid;
  logic               tap_ready;
  logic [1:0]         tap_chan;
  logic [COORD_W:0]   tap_x;
  logic [COORD_W:0]   tap_y;
  logic [KSIZE_W-1:0] tap_kx;
  logic [KSIZE_W-1:0] tap_ky;
  logic               tap_pad;
  logic               tap_first;
  logic               tap_last;

  modport master (
    output tap_valid, tap_chan, tap_x, tap_y, tap_kx, tap_ky, tap_pad, tap_first, tap_last,
    input  tap_ready
  );

  modport slave (
    input  tap_valid, tap_chan, tap_x, tap_y, tap_kx, tap_ky, tap_pad, tap_first, tap_last,
    output tap_ready
  );
endinterface

// File: rtl/conv_tap_sequencer.sv
// Walks every (chan, y, x, ky, kx) tap of a 3-channel frame; first tap 2 cycles after start, done 1 cycle after the last one.
// Counters advance only on a tap handshake, so the payload holds while tap_ready is low.
module conv_tap_sequencer #(
  parameter int COORD_W = 16,
  parameter int KSIZE_W = 4
) (
  input  logic                Clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [COORD_W-1:0]  img_width,
  input  logic [COORD_W-1:0]  img_height,
  input  logic [KSIZE_W-1:0]  kernel_size,
  output logic                busy,
  output logic                done,
  output logic                err,
  conv_tap_sequencer_if.master tap
);

  localparam int XW = COORD_W + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t stateQ;
  state_t stateD;

  logic [COORD_W-1:0] cfgW;
  logic [COORD_W-1:0] cfgH;
  logic [KSIZE_W-1:0] cfgK;
  logic               errQ;

  logic [1:0]         chanQ;
  logic [COORD_W-1:0] yQ;
  logic [COORD_W-1:0] xQ;
  logic [KSIZE_W-1:0] kyQ;
  logic [KSIZE_W-1:0] kxQ;

  logic               cfgOk;
  logic [KSIZE_W-1:0] kLast;
  logic [KSIZE_W-1:0] center;
  logic [COORD_W-1:0] wLast;
  logic [COORD_W-1:0] hLast;
  logic               kxWrap;
  logic               kyWrap;
  logic               xWrap;
  logic               yWrap;
  logic               chanWrap;
  logic               lastTap;
  logic               xfer;
  logic               runValid;

  logic signed [XW-1:0] srcX;
  logic signed [XW-1:0] srcY;
  logic signed [XW-1:0] limW;
  logic signed [XW-1:0] limH;

  // An odd K is also a non-zero K.
  assign cfgOk  = (cfgW != '0) && (cfgH != '0) && cfgK[0];
  assign kLast  = cfgK - 1'b1;
  assign center = kLast >> 1;
  assign wLast  = cfgW - 1'b1;
  assign hLast  = cfgH - 1'b1;

  assign kxWrap   = (kxQ == kLast);
  assign kyWrap   = (kyQ == kLast);
  assign xWrap    = (xQ == wLast);
  assign yWrap    = (yQ == hLast);
  assign chanWrap = (chanQ == 2'd2);
  assign lastTap  = kxWrap && kyWrap && xWrap && yWrap && chanWrap;

  assign runValid = (stateQ == RUN);
  assign xfer     = runValid && tap.tap_ready;

  // Source coordinates carry two guard bits so the pad test cannot wrap.
  always_comb begin
    srcX = $signed({2'b00, xQ}) + $signed({{(XW-KSIZE_W){1'b0}}, kxQ})
         - $signed({{(XW-KSIZE_W){1'b0}}, center});
    srcY = $signed({2'b00, yQ}) + $signed({{(XW-KSIZE_W){1'b0}}, kyQ})
         - $signed({{(XW-KSIZE_W){1'b0}}, center});
    limW = $signed({2'b00, cfgW});
    limH = $signed({2'b00, cfgH});
  end

  assign tap.tap_chan = chanQ;
  assign tap.tap_x    = srcX[COORD_W:0];
  assign tap.tap_y    = srcY[COORD_W:0];
  assign tap.tap_kx   = kxQ;
  assign tap.tap_ky   = kyQ;
  assign tap.tap_pad  = (srcX < 0) || (srcX >= limW) || (srcY < 0) || (srcY >= limH);
  assign err          = errQ;

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      stateQ <= IDLE;
    end else begin
      stateQ <= stateD;
    end
  end

  always_comb begin
    stateD        = stateQ;
    busy          = 1'b0;
    done          = 1'b0;
    tap.tap_valid = 1'b0;
    tap.tap_first = 1'b0;
    tap.tap_last  = 1'b0;
    unique case (stateQ)
      IDLE: begin
        if (start) begin
          stateD = LOAD;
        end
      end
      LOAD: begin
        busy   = 1'b1;
        stateD = cfgOk ? RUN : DONE;
      end
      RUN: begin
        busy          = 1'b1;
        tap.tap_valid = 1'b1;
        tap.tap_first = (kxQ == '0) && (kyQ == '0);
        tap.tap_last  = kxWrap && kyWrap;
        if (xfer && lastTap) begin
          stateD = DONE;
        end
      end
      DONE: begin
        done   = 1'b1;
        stateD = IDLE;
      end
      default: begin
        stateD = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      cfgW  <= '0;
      cfgH  <= '0;
      cfgK  <= '0;
      errQ  <= 1'b0;
      chanQ <= '0;
      yQ    <= '0;
      xQ    <= '0;
      kyQ   <= '0;
      kxQ   <= '0;
    end else begin
      if ((stateQ == IDLE) && start) begin
        cfgW  <= img_width;
        cfgH  <= img_height;
        cfgK  <= kernel_size;
        errQ  <= 1'b0;
        chanQ <= '0;
        yQ    <= '0;
        xQ    <= '0;
        kyQ   <= '0;
        kxQ   <= '0;
      end

      if ((stateQ == LOAD) && !cfgOk) begin
        errQ <= 1'b1;
      end

      // Odometer: kx innermost, each wrap carries outward; the final tap leaves all at zero.
      if (xfer) begin
        if (!kxWrap) begin
          kxQ <= kxQ + 1'b1;
        end else begin
          kxQ <= '0;
          if (!kyWrap) begin
            kyQ <= kyQ + 1'b1;
          end else begin
            kyQ <= '0;
            if (!xWrap) begin
              xQ <= xQ + 1'b1;
            end else begin
              xQ <= '0;
              if (!yWrap) begin
                yQ <= yQ + 1'b1;
              end else begin
                yQ    <= '0;
                chanQ <= chanWrap ? 2'd0 : chanQ + 1'b1;
              end
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_tap_sequencer.sv
module tb_conv_tap_sequencer;
  localparam int CW = 16;
  localparam int KW = 4;

  typedef struct packed {
    logic [1:0]    chan;
    logic [CW:0]   x;
    logic [CW:0]   y;
    logic [KW-1:0] kx;
    logic [KW-1:0] ky;
    logic          pad;
    logic          first;
    logic          last;
  } tap_t;

  logic          Clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] imgW = '0;
  logic [CW-1:0] imgH = '0;
  logic [KW-1:0] kSize = '0;
  logic          busy;
  logic          done;
  logic          err;

  int   testCount = 0;
  int   failCount = 0;
  tap_t expQ[$];

  conv_tap_sequencer_if #(.COORD_W(CW), .KSIZE_W(KW)) tapIf();

  conv_tap_sequencer #(.COORD_W(CW), .KSIZE_W(KW)) dut (
    .Clk         (Clk),
    .reset_n     (reset_n),
    .start       (start),
    .img_width   (imgW),
    .img_height  (imgH),
    .kernel_size (kSize),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .tap         (tapIf.master)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic tap_t observed();
    tap_t t;
    t.chan  = tapIf.tap_chan;
    t.x     = tapIf.tap_x;
    t.y     = tapIf.tap_y;
    t.kx    = tapIf.tap_kx;
    t.ky    = tapIf.tap_ky;
    t.pad   = tapIf.tap_pad;
    t.first = tapIf.tap_first;
    t.last  = tapIf.tap_last;
    return t;
  endfunction

  // Reference loop nest: every tap of the frame in issue order.
  task automatic pushModel(input int w, input int h, input int k);
    tap_t t;
    int   c;
    int   sx;
    int   sy;
    c = (k - 1) / 2;
    for (int ch = 0; ch < 3; ch++)
      for (int y = 0; y < h; y++)
        for (int x = 0; x < w; x++)
          for (int ky = 0; ky < k; ky++)
            for (int kx = 0; kx < k; kx++) begin
              sx      = x + kx - c;
              sy      = y + ky - c;
              t.chan  = 2'(ch);
              t.x     = 17'(sx);
              t.y     = 17'(sy);
              t.kx    = 4'(kx);
              t.ky    = 4'(ky);
              t.pad   = (sx < 0) || (sx >= w) || (sy < 0) || (sy >= h);
              t.first = (kx == 0) && (ky == 0);
              t.last  = (kx == k - 1) && (ky == k - 1);
              expQ.push_back(t);
            end
  endtask

  // readyMode 0: ready held high; 1: random with a forced 5-cycle low burst.
  // abortAt >= 0: pulse start at that tap count, then reset 5 taps later.
  task automatic runFrame(input int w, input int h, input int k, input int readyMode, input int abortAt);
    int   hs;
    int   cyc;
    int   budget;
    int   expTotal;
    int   lastHsCyc;
    bit   cfgValid;
    bit   sawDone;
    bit   stalled;
    bit   pulsed;
    bit   r;
    tap_t held;
    hs = 0; cyc = 0; lastHsCyc = -10; sawDone = 0; stalled = 0; pulsed = 0;
    expQ.delete();
    cfgValid = (w >= 1) && (h >= 1) && (k % 2 == 1);
    if (cfgValid) pushModel(w, h, k);
    expTotal = expQ.size();

    @(negedge Clk);
    imgW = 16'(w); imgH = 16'(h); kSize = 4'(k); start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    imgW = '1; imgH = '0; kSize = 4'd2;
    check("load_busy", busy, 1);
    check("load_valid", tapIf.tap_valid, 0);
    check("load_err_clear", err, 0);
    tapIf.tap_ready = 1'b1;

    if (!cfgValid) begin
      @(negedge Clk);
      check("bad_done", done, 1);
      check("bad_err", err, 1);
      check("bad_valid", tapIf.tap_valid, 0);
      check("bad_busy", busy, 0);
      @(negedge Clk);
      check("bad_idle_done", done, 0);
      check("bad_err_held", err, 1);
      check("bad_idle_valid", tapIf.tap_valid, 0);
      return;
    end

    budget = expTotal * 8 + 200;
    while (cyc < budget) begin
      @(negedge Clk);
      cyc++;
      if (pulsed) start = 1'b0;
      if (cyc == 1) check("first_valid_n2", tapIf.tap_valid, 1);
      if (done) begin
        sawDone = 1;
        break;
      end
      if (abortAt >= 0 && hs == abortAt + 5) begin
        #2 reset_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_valid", tapIf.tap_valid, 0);
        check("rst_first", tapIf.tap_first, 0);
        repeat (3) begin
          @(negedge Clk);
          check("rst_no_done", done, 0);
        end
        tapIf.tap_ready = 1'b0;
        reset_n = 1'b1;
        return;
      end
      check("run_valid", tapIf.tap_valid, 1);
      if (stalled) check("stall_stable", observed(), held);
      if (abortAt >= 0 && hs == abortAt && !pulsed) begin
        start  = 1'b1;
        pulsed = 1;
      end
      if (readyMode == 0) r = 1'b1;
      else if (cyc >= 20 && cyc < 25) r = 1'b0;
      else r = 1'($urandom_range(0, 1));
      tapIf.tap_ready = r;
      if (r) begin
        if (expQ.size() == 0) begin
          check("extra_tap", 1, 0);
        end else begin
          check($sformatf("tap%0d", hs), observed(), expQ.pop_front());
        end
        hs++;
        lastHsCyc = cyc;
        stalled = 0;
      end else begin
        held    = observed();
        stalled = 1;
      end
    end

    tapIf.tap_ready = 1'b0;
    check("frame_finished", sawDone, 1);
    check("tap_total", hs, expTotal);
    check("done_latency", cyc, lastHsCyc + 1);
    check("done_busy", busy, 0);
    check("done_valid", tapIf.tap_valid, 0);
    check("done_err", err, 0);
    @(negedge Clk);
    check("idle_done", done, 0);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    tapIf.tap_ready = 1'b0;
    reset_n = 1'b0;
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    check("reset_valid", tapIf.tap_valid, 0);
    check("reset_first", tapIf.tap_first, 0);
    check("reset_last", tapIf.tap_last, 0);
    repeat (2) @(negedge Clk);
    reset_n = 1'b1;

    runFrame(1, 1, 1, 0, -1);
    runFrame(3, 2, 3, 0, -1);
    runFrame(3, 2, 3, 1, -1);
    runFrame(2, 2, 4, 0, -1);
    runFrame(0, 2, 3, 0, -1);
    runFrame(2, 2, 0, 0, -1);
    runFrame(3, 2, 3, 0, 40);
    runFrame(3, 2, 3, 0, -1);
    runFrame(4, 4, 5, 0, -1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end
endmodule
